// File: rtl/alu_pipe_if.sv
// Issue-side and result-side handshake bundle for alu_pipe.
// The issuer drives operations and the result ready; the pipe answers with
// in_ready, the registered result, its flags and the completed-op counter.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);

   // Operation issue channel
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [2:0]       opcode;
   logic             sat;

   // Result channel
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   // Completed-operation counter
   logic [CNT_W-1:0] op_count;

   // Issue logic / result consumer side
   modport master (
      output in_valid,
      output in1,
      output in2,
      output opcode,
      output sat,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out,
      input  flag_z,
      input  flag_c,
      input  flag_v,
      input  op_count
   );

   // ALU pipe side
   modport slave (
      input  in_valid,
      input  in1,
      input  in2,
      input  opcode,
      input  sat,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out,
      output flag_z,
      output flag_c,
      output flag_v,
      output op_count
   );

endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control on both sides.
// Stage 1 captures the operands, stage 2 computes and holds the result and
// flags until the consumer takes them. Results leave strictly in order.
module alu_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16,
   localparam int unsigned SH_W = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001,
      OpAnd = 3'b010,
      OpOr  = 3'b011,
      OpXor = 3'b100,
      OpSll = 3'b101,
      OpSrl = 3'b110,
      OpSra = 3'b111
   } op_e;

   localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   op_e              s1_op_q;
   logic             s1_sat_q;

   // Stage 2 state
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] res_q;
   logic             z_q, c_q, v_q;
   logic [CNT_W-1:0] cnt_q;

   // Handshake terms
   logic s1_load;
   logic s2_load;
   logic out_xfer;
   logic in_ready;

   // Stage 2 next values
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] res_d;
   logic             z_d, c_d, v_d;

   // Flow control; in_ready depends combinationally on out_ready so a full
   // pipe can still accept when the consumer drains in the same cycle.
   always_comb begin
      s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
      in_ready = !s1_valid_q || s2_load;
      s1_load  = bus.in_valid && in_ready;
      out_xfer = s2_valid_q && bus.out_ready;
   end

   // Valid-bit next state for both stages
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (s1_load) begin
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      // A load in the same cycle as a transfer keeps out_valid high
      if (s2_load) begin
         s2_valid_d = 1'b1;
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end
   end

   // Valid bits; reset discards anything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // Stage 1 operand capture on an input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_op_q  <= OpAdd;
         s1_sat_q <= 1'b0;
      end else if (s1_load) begin
         s1_a_q   <= bus.in1;
         s1_b_q   <= bus.in2;
         s1_op_q  <= op_e'(bus.opcode);
         s1_sat_q <= bus.sat;
      end
   end

   // Stage 2 datapath: result, raw flags, then optional signed clamp
   always_comb begin
      sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      shamt  = s1_b_q[SH_W-1:0];
      res_d  = '0;
      c_d    = 1'b0;
      v_d    = 1'b0;
      unique case (s1_op_q)
         OpAdd: begin
            res_d = sum_w[WIDTH-1:0];
            c_d   = sum_w[WIDTH];
            v_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OpSub: begin
            res_d = diff_w[WIDTH-1:0];
            // Borrow out of the extended subtraction means in1 < in2 unsigned
            c_d   = diff_w[WIDTH];
            v_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OpAnd: res_d = s1_a_q & s1_b_q;
         OpOr:  res_d = s1_a_q | s1_b_q;
         OpXor: res_d = s1_a_q ^ s1_b_q;
         OpSll: res_d = s1_a_q << shamt;
         OpSrl: res_d = s1_a_q >> shamt;
         OpSra: res_d = $signed(s1_a_q) >>> shamt;
         default: res_d = '0;
      endcase
      // On overflow the true result's sign is the sign of in1
      if (s1_sat_q && v_d) begin
         res_d = s1_a_q[WIDTH-1] ? SatMin : SatMax;
      end
      z_d = (res_d == '0);
   end

   // Stage 2 registers hold while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
      end else if (s2_load) begin
         res_q <= res_d;
         z_q   <= z_d;
         c_q   <= c_d;
         v_q   <= v_d;
      end
   end

   // Completed-operation counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (out_xfer) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Output drive
   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = s2_valid_q;
      bus.out       = res_q;
      bus.flag_z    = z_q;
      bus.flag_c    = c_q;
      bus.flag_v    = v_q;
      bus.op_count  = cnt_q;
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes hand-computed expected
// results when an operation is accepted; the monitor pops and compares on
// every output transfer and checks that a stalled result holds steady.
module tb_alu_pipe;

   localparam int unsigned W = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
   } exp_t;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      exp_t         e;
   } vec_t;

   localparam int NV = 18;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   exp_t sb[$];
   logic held_v;
   exp_t held;
   vec_t vecs[NV];

   alu_pipe_if #(.WIDTH(W), .CNT_W(16)) bus ();

   alu_pipe #(
      .WIDTH(W),
      .CNT_W(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: compares each output transfer against the scoreboard head
   always @(negedge clk) begin
      if (held_v && bus.out_valid) begin
         chk("hold_out", 64'(bus.out), 64'(held.res));
         chk("hold_flags", 64'({bus.flag_z, bus.flag_c, bus.flag_v}),
             64'({held.z, held.c, held.v}));
      end
      held_v <= bus.out_valid && !bus.out_ready;
      held   <= '{bus.out, bus.flag_z, bus.flag_c, bus.flag_v};
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: got out=%h, required no output", bus.out);
         end else begin
            chk("result", 64'(bus.out), 64'(sb[0].res));
            chk("flags", 64'({bus.flag_z, bus.flag_c, bus.flag_v}),
                64'({sb[0].z, sb[0].c, sb[0].v}));
            void'(sb.pop_front());
         end
      end
   end

   // Offer one op from posedge+1; returns at posedge+1 after acceptance
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input exp_t e, input bit track);
      int waited = 0;
      bus.opcode   = op;
      bus.in1      = a;
      bus.in2      = b;
      bus.sat      = s;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            if (track) sb.push_back(e);
            break;
         end
         waited++;
         if (waited > 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   // ADD 5+2 on an empty pipe: transfer happens at the second edge after acceptance
   task automatic latency_add(input int unsigned exp_cnt);
      bus.out_ready = 1'b1;
      send(OP_ADD, 32'd5, 32'd2, 1'b0, '{32'd7, 1'b0, 1'b0, 1'b0}, 1'b1);
      bus.in_valid = 1'b0;
      chk("lat_e0_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_e1_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      chk("lat_e2_count", 64'(bus.op_count), 64'(exp_cnt));
      chk("lat_e2_valid", 64'(bus.out_valid), 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      held_v = 1'b0;
      held   = '0;
      vecs[0]  = '{OP_ADD, 32'd5,         32'd2,         1'b0, '{32'h0000_0007, 1'b0, 1'b0, 1'b0}};
      vecs[1]  = '{OP_SUB, 32'd2,         32'd5,         1'b0, '{32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0}};
      vecs[2]  = '{OP_SUB, 32'd5,         32'd5,         1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}};
      vecs[3]  = '{OP_ADD, 32'h7FFF_FFFF, 32'd1,         1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b1}};
      vecs[4]  = '{OP_ADD, 32'h7FFF_FFFF, 32'd1,         1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1}};
      vecs[5]  = '{OP_SUB, 32'h8000_0000, 32'd1,         1'b1, '{32'h8000_0000, 1'b0, 1'b0, 1'b1}};
      vecs[6]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,         1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b0}};
      vecs[7]  = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b1}};
      vecs[8]  = '{OP_SLL, 32'd1,         32'h0000_0025, 1'b0, '{32'h0000_0020, 1'b0, 1'b0, 1'b0}};
      vecs[9]  = '{OP_SLL, 32'h0000_1234, 32'h0000_0020, 1'b0, '{32'h0000_1234, 1'b0, 1'b0, 1'b0}};
      vecs[10] = '{OP_SRA, 32'h8000_0000, 32'd4,         1'b0, '{32'hF800_0000, 1'b0, 1'b0, 1'b0}};
      vecs[11] = '{OP_SRL, 32'h8000_0000, 32'd4,         1'b0, '{32'h0800_0000, 1'b0, 1'b0, 1'b0}};
      vecs[12] = '{OP_SRA, 32'h8000_0000, 32'd31,        1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
      vecs[13] = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, '{32'hF000_F000, 1'b0, 1'b0, 1'b0}};
      vecs[14] = '{OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, '{32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0}};
      vecs[15] = '{OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, '{32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0}};
      vecs[16] = '{OP_SRL, 32'd1,         32'd1,         1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b0}};
      vecs[17] = '{OP_ADD, 32'd5,         32'd2,         1'b1, '{32'h0000_0007, 1'b0, 1'b0, 1'b0}};

      // Reset state
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in1       = '0;
      bus.in2       = '0;
      bus.opcode    = '0;
      bus.sat       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out", 64'(bus.out), 64'd0);
      chk("rst_flags", 64'({bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
      chk("rst_count", 64'(bus.op_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Single op latency, then the directed vectors back to back
      latency_add(1);
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, 1'b1);
      end
      bus.in_valid = 1'b0;
      drain();
      chk("stream_count", 64'(bus.op_count), 64'(1 + NV));

      // Backpressure: two ops fill the pipe, the third waits
      bus.out_ready = 1'b0;
      send(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, '{32'h5555_5555, 1'b0, 1'b0, 1'b0}, 1'b1);
      send(OP_SUB, 32'd10, 32'd3, 1'b0, '{32'h0000_0007, 1'b0, 1'b0, 1'b0}, 1'b1);
      bus.opcode   = OP_OR;
      bus.in1      = '0;
      bus.in2      = '0;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      sb.push_back('{32'h0000_0000, 1'b1, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      chk("bp_count", 64'(bus.op_count), 64'(4 + NV));
      chk("bp_empty_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);

      // Reset with two untracked ops in flight
      bus.out_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd1, 1'b0, '0, 1'b0);
      send(OP_ADD, 32'd2, 32'd2, 1'b0, '0, 1'b0);
      bus.in_valid = 1'b0;
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_out", 64'(bus.out), 64'd0);
      chk("mid_rst_count", 64'(bus.op_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_out", 64'(bus.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      latency_add(1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required earlier finish");
      $fatal(1);
   end

endmodule
